// File: rtl/music_box_pkg.sv
// Types and constants shared by the music-box playback blocks.
package music_box_pkg;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, LATCH, TONE, GAP} state_t;

   localparam logic [1:0] DUR_1B = 2'b00;
   localparam logic [1:0] DUR_2B = 2'b01;
   localparam logic [1:0] DUR_3B = 2'b10;
   localparam logic [1:0] DUR_4B = 2'b11;

   localparam int unsigned REST_PERIOD         = 0;
   localparam int unsigned DEFAULT_BEAT_CYCLES = 25_000_000;
   localparam int unsigned DEFAULT_GAP_CYCLES  = 1_000_000;

   // Audible part of a note slot; the remaining gap cycles are silent.
   function automatic int unsigned slot_cycles(input logic [1:0]  dur,
                                               input int unsigned beat,
                                               input int unsigned gap);
      return (32'(dur) + 32'd1) * beat - gap;
   endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles speaker every `period` enabled cycles, silent when disabled or resting.
module tone_gen
   import music_box_pkg::*;
#(
   parameter int PERIOD_W = 20
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [PERIOD_W-1:0] period,
   output logic                speaker
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                speaker_q, speaker_d;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      cnt_d     = '0;
      speaker_d = 1'b0;
      if (en && period != PERIOD_W'(REST_PERIOD)) begin
         if (cnt_q == period - 1'b1) begin
            speaker_d = ~speaker_q;
         end else begin
            cnt_d     = cnt_q + 1'b1;
            speaker_d = speaker_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      if (reset) begin
         cnt_q     <= '0;
         speaker_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         speaker_q <= speaker_d;
      end
   end

   assign speaker = speaker_q;

endmodule

// File: rtl/note_player.sv
// Plays song-memory notes as timed square waves with an articulation gap, then reports the end marker.
module note_player
   import music_box_pkg::*;
#(
   parameter int PERIOD_W    = 20,
   parameter int BEAT_CYCLES = DEFAULT_BEAT_CYCLES,
   parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES,
   parameter int LATCH_DELAY = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                play,
   input  logic                stop,
   input  logic [PERIOD_W-1:0] note_period,
   input  logic [1:0]          duration,
   output logic                next_note,
   output logic                speaker,
   output logic                busy,
   output logic                song_done
);

   // One counter serves WAIT, the audible slot and GAP; sized for a four-beat slot.
   localparam int CNT_W = $clog2(4 * BEAT_CYCLES + LATCH_DELAY + 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                next_note_q, next_note_d;
   logic                song_done_q, song_done_d;
   logic                busy_q, busy_d;
   logic                tone_en;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      period_d    = period_q;
      song_done_d = 1'b0;
      if (stop) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (play) begin
         state_d = REQ;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: ;
            REQ: begin
               state_d = WAIT;
               cnt_d   = CNT_W'(LATCH_DELAY);
            end
            WAIT: begin
               if (cnt_q <= CNT_W'(1)) state_d = LATCH;
               else                    cnt_d   = cnt_q - 1'b1;
            end
            LATCH: begin
               period_d = note_period;
               if (note_period == PERIOD_W'(REST_PERIOD) && duration == DUR_1B) begin
                  song_done_d = 1'b1;
                  state_d     = IDLE;
                  cnt_d       = '0;
               end else begin
                  state_d = TONE;
                  cnt_d   = CNT_W'(slot_cycles(duration, BEAT_CYCLES, GAP_CYCLES));
               end
            end
            TONE: begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = GAP;
                  cnt_d   = CNT_W'(GAP_CYCLES);
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            GAP: begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = REQ;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      // A play landing on REQ re-enters REQ; suppress the second advance pulse.
      next_note_d = (state_d == REQ) && (state_q != REQ);
      busy_d      = (state_d != IDLE);
   end

   // Disabling on the last TONE cycle keeps the speaker low for the whole gap and after stop/restart.
   assign tone_en = (state_q == TONE) && (state_d == TONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         period_q    <= '0;
         next_note_q <= 1'b0;
         song_done_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         period_q    <= period_d;
         next_note_q <= next_note_d;
         song_done_q <= song_done_d;
         busy_q      <= busy_d;
      end
   end

   tone_gen #(.PERIOD_W(PERIOD_W)) u_tone_gen (
      .clk     (clk),
      .reset   (reset),
      .en      (tone_en),
      .period  (period_q),
      .speaker (speaker)
   );

   assign next_note = next_note_q;
   assign song_done = song_done_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: song-memory stand-in, slot-timeline reference model and directed scenarios.
module tb_note_player;
   import music_box_pkg::*;

   localparam int PW   = 20;
   localparam int BEAT = 16;
   localparam int GAP  = 2;
   localparam int LD   = 2;

   logic          clk, reset, play, stop;
   logic [PW-1:0] note_period;
   logic [1:0]    duration;
   logic          next_note, speaker, busy, song_done;

   note_player #(
      .PERIOD_W(PW), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .LATCH_DELAY(LD)
   ) dut (
      .clk(clk), .reset(reset), .play(play), .stop(stop),
      .note_period(note_period), .duration(duration),
      .next_note(next_note), .speaker(speaker), .busy(busy), .song_done(song_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
   endtask

   // Song memory: each next_note pulse presents the next entry (end marker past the end).
   typedef struct packed {
      logic [PW-1:0] note;
      logic [1:0]    dur;
   } entry_t;

   entry_t song[$];
   int     mem_ptr;

   task automatic add_note(input int n, input int d);
      entry_t e;
      e.note = PW'(n);
      e.dur  = 2'(d);
      song.push_back(e);
   endtask

   initial begin
      note_period = PW'(7);
      duration    = 2'b10;
      forever begin
         @(negedge clk);
         if (next_note === 1'b1) begin
            if (mem_ptr < song.size()) begin
               note_period = song[mem_ptr].note;
               duration    = song[mem_ptr].dur;
            end else begin
               note_period = '0;
               duration    = 2'b00;
            end
            mem_ptr++;
         end
      end
   end

   // Reference model: position inside the note timeline (offset 0 = request cycle).
   int cyc = 0;
   bit m_active = 1'b0;
   int m_off = 0;
   bit m_done = 1'b0;
   int m_p = 0;
   int m_t = 0;
   int nn_times[$];
   int edges_at_nn[$];
   int spk_edges = 0;
   logic spk_prev = 1'b0;
   int play_cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;

   initial begin
      logic r, p, s;
      logic [PW-1:0] nt;
      logic [1:0] du;
      bit prev_req, exp_nn, exp_spk;
      int k;
      forever begin
         @(posedge clk);
         r = reset; p = play; s = stop; nt = note_period; du = duration;
         cyc++;
         prev_req = m_active && (m_off == 0);
         m_done   = 1'b0;
         if (r || s) begin
            m_active = 1'b0;
         end else if (p) begin
            m_active = 1'b1;
            m_off    = 0;
            play_cyc = cyc - 1;
         end else if (m_active) begin
            m_off++;
            if (m_off == LD + 2) begin
               if (nt == 0 && du == 2'b00) begin
                  m_done   = 1'b1;
                  m_active = 1'b0;
               end else begin
                  m_p = int'(nt);
                  m_t = (int'(du) + 1) * BEAT - GAP;
               end
            end else if (m_off > LD + 2 && m_off == LD + 2 + m_t + GAP) begin
               m_off = 0;
            end
         end
         exp_nn  = m_active && (m_off == 0) && !prev_req;
         exp_spk = 1'b0;
         if (m_active && m_off >= LD + 2) begin
            k = m_off - (LD + 1);
            if (k <= m_t && m_p != 0) exp_spk = (((k - 1) / m_p) % 2) == 1;
         end
         #1;
         check($sformatf("busy@%0d", cyc), busy, m_active);
         check($sformatf("next_note@%0d", cyc), next_note, exp_nn);
         check($sformatf("song_done@%0d", cyc), song_done, m_done);
         check($sformatf("speaker@%0d", cyc), speaker, exp_spk);
         if (next_note === 1'b1) begin
            nn_times.push_back(cyc);
            edges_at_nn.push_back(spk_edges);
         end
         if (speaker !== spk_prev) spk_edges++;
         spk_prev = speaker;
         if (song_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic start_song();
      mem_ptr = 0;
      nn_times.delete();
      edges_at_nn.delete();
      play = 1'b1;
      @(negedge clk);
      play = 1'b0;
   endtask

   task automatic wait_speaker_high(input string name, input int limit);
      bit found = 1'b0;
      for (int i = 0; i < limit && !found; i++) begin
         @(negedge clk);
         if (speaker === 1'b1) found = 1'b1;
      end
      check(name, found, 1'b1);
   endtask

   initial begin
      int n0;
      bit got;
      reset = 1'b1; play = 1'b0; stop = 1'b0; mem_ptr = 0;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_speaker", speaker, 0);
      check("reset_next_note", next_note, 0);
      check("reset_song_done", song_done, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Full song: staccato note, long note, rest, end marker.
      song.delete();
      add_note(3, 0); add_note(5, 3); add_note(0, 1);
      start_song();
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (done_cnt > 0) got = 1'b1;
      end
      check("song_done_seen", got, 1'b1);
      repeat (100) @(negedge clk);
      check("song_next_note_count", nn_times.size(), 4);
      check("song_done_count", done_cnt, 1);
      check("song_idle_busy", busy, 0);
      if (nn_times.size() == 4) begin
         check("play_to_next_note", nn_times[0] - play_cyc, 1);
         check("slot1_spacing", nn_times[1] - nn_times[0], 20);
         check("slot2_spacing", nn_times[2] - nn_times[1], 68);
         check("slot3_spacing", nn_times[3] - nn_times[2], 36);
         check("slot1_toggles", edges_at_nn[1] - edges_at_nn[0], 4);
         check("slot2_toggles", edges_at_nn[2] - edges_at_nn[1], 12);
         check("slot3_toggles", edges_at_nn[3] - edges_at_nn[2], 0);
         check("marker_to_done", done_cyc - nn_times[3], LD + 2);
      end

      // Stop while the speaker is high, then restart.
      song.delete();
      add_note(3, 0); add_note(3, 0); add_note(3, 0);
      start_song();
      wait_speaker_high("stop_setup_speaker_high", 60);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("stop_speaker", speaker, 0);
      check("stop_busy", busy, 0);
      check("stop_next_note", next_note, 0);
      n0 = nn_times.size();
      repeat (5) @(negedge clk);
      check("stop_no_more_next_note", nn_times.size(), n0);
      start_song();
      check("restart_next_note", next_note, 1);

      // Play while busy restarts at the request.
      wait_speaker_high("replay_setup_speaker_high", 60);
      play = 1'b1;
      @(negedge clk);
      play = 1'b0;
      check("replay_next_note", next_note, 1);
      check("replay_speaker", speaker, 0);
      check("replay_busy", busy, 1);

      // Reset during the gap of that note.
      repeat (18) @(negedge clk);
      check("gap_busy", busy, 1);
      check("gap_speaker", speaker, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("gap_reset_busy", busy, 0);
      check("gap_reset_speaker", speaker, 0);
      check("gap_reset_next_note", next_note, 0);
      n0 = nn_times.size();
      repeat (30) @(negedge clk);
      check("gap_reset_quiet", nn_times.size(), n0);

      // Play and stop together mid-note: stop wins.
      start_song();
      repeat (8) @(negedge clk);
      n0 = nn_times.size();
      play = 1'b1; stop = 1'b1;
      @(negedge clk);
      play = 1'b0; stop = 1'b0;
      check("play_stop_busy", busy, 0);
      check("play_stop_next_note", next_note, 0);
      check("play_stop_speaker", speaker, 0);
      repeat (20) @(negedge clk);
      check("play_stop_quiet", nn_times.size(), n0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
